// File: rtl/ariane_pkg.sv
// Shared decode/issue types for the scoreboard slice.
// Also holds the default scoreboard depth.
package ariane_pkg;

  localparam int          NR_SB_ENTRIES = 8;
  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ALU  = 3'd1,
    MULT = 3'd2,
    LSU  = 3'd3,
    CSR  = 3'd4
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
    logic        use_pc;
    exception_t  ex;
  } scoreboard_entry_t;

  // Entries that faulted at decode or need no FU are born complete and never issue.
  function automatic logic skips_issue(input scoreboard_entry_t e);
    return e.ex.valid | (e.fu == NONE);
  endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// RAW hazard detection against the in-flight window [commit_ptr, issue_ptr).
// No forwarding: a matching producer blocks until it retires.
module sb_hazard_check
  import ariane_pkg::*;
#(
  parameter int  NR_ENTRIES = NR_SB_ENTRIES,
  localparam int PTR_W      = $clog2(NR_ENTRIES)
) (
  input  scoreboard_entry_t entries [NR_ENTRIES],
  input  logic [PTR_W-1:0]  commit_ptr,
  input  logic [PTR_W-1:0]  issue_ptr,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              use_imm,
  input  logic              use_pc,
  output logic              hazard
);

  logic [PTR_W-1:0] span_s;
  logic [PTR_W-1:0] slot_s;
  logic             live_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             unused_s;

  // Scan the in-flight window for a destination matching either source.
  always_comb begin
    span_s    = issue_ptr - commit_ptr;
    slot_s    = commit_ptr;
    live_s    = 1'b0;
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    unused_s  = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      slot_s    = commit_ptr + PTR_W'(i);
      live_s    = (i < int'(span_s));
      rs1_hit_s = rs1_hit_s | (live_s & (entries[slot_s].rd == rs1));
      rs2_hit_s = rs2_hit_s | (live_s & (entries[slot_s].rd == rs2));
      unused_s  = unused_s ^ (^entries[i]);
    end
    hazard = (rs1_hit_s & (rs1 != 5'd0) & ~use_pc) |
             (rs2_hit_s & (rs2 != 5'd0) & ~use_imm);
  end

endmodule

// File: rtl/scoreboard_checker.sv
// Protocol checks for the scoreboard: writebacks must target an in-flight slot.
module scoreboard_checker #(
  parameter int NR_ENTRIES = 8
) (
  input logic                  clk_i,
  input logic                  active,
  input logic                  wb_valid,
  input logic [4:0]            trans_id,
  input logic [NR_ENTRIES-1:0] issued
);

  localparam int PTR_W = $clog2(NR_ENTRIES);

  logic [PTR_W-1:0] idx_s;
  assign idx_s = trans_id[PTR_W-1:0];

  wb_in_flight_a: assert property (@(posedge clk_i)
    (active && wb_valid) |-> (({1'b0, trans_id} < 6'(NR_ENTRIES)) && issued[idx_s]))
    else $error("scoreboard: writeback to slot %0d that is not in flight", trans_id);

endmodule

// File: rtl/scoreboard.sv
// In-order issue/commit scoreboard; trans_id is the circular-buffer slot index.
// SCOREBOARD_COMMIT_BYPASS_EN: writeback to the commit slot is visible to commit in the same cycle.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int NR_ENTRIES = NR_SB_ENTRIES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              full_o,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_instr_valid_o,
  input  logic              issue_ack_i,
  input  logic [4:0]        trans_id_i,
  input  logic [63:0]       wdata_i,
  input  exception_t        ex_i,
  input  logic              wb_valid_i,
  output scoreboard_entry_t commit_instr_o,
  output logic              commit_valid_o,
  input  logic              commit_ack_i
);

  localparam int PTR_W = $clog2(NR_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  scoreboard_entry_t     mem_r [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] issued_r;
  logic [PTR_W-1:0]      alloc_ptr_r, issue_ptr_r, commit_ptr_r;
  logic [CNT_W-1:0]      count_r, n_issued_r;
  logic                  clear_r;

  logic              block_s, full_s, alloc_s, pending_s, skip_s, hazard_s;
  logic              issue_valid_s, issue_fire_s, issue_adv_s;
  logic              wb_ok_s, commit_valid_s, commit_fire_s;
  logic [PTR_W-1:0]  wb_idx_s;
  scoreboard_entry_t new_entry_s, issue_entry_s, commit_entry_s;

  assign issue_entry_s = mem_r[issue_ptr_r];

  // Handshake decisions; clear_r keeps outputs quiet for the cycle after reset/flush.
  always_comb begin
    block_s       = rst_i | flush_i | clear_r;
    full_s        = (count_r == CNT_W'(NR_ENTRIES));
    alloc_s       = decoded_instr_valid_i & ~full_s & ~block_s;
    pending_s     = (count_r != n_issued_r);
    skip_s        = pending_s & issued_r[issue_ptr_r] & ~block_s;
    issue_valid_s = pending_s & ~issued_r[issue_ptr_r] & ~hazard_s & ~block_s;
    issue_fire_s  = issue_valid_s & issue_ack_i;
    issue_adv_s   = skip_s | issue_fire_s;
    wb_idx_s      = trans_id_i[PTR_W-1:0];
    wb_ok_s       = wb_valid_i & ({1'b0, trans_id_i} < 6'(NR_ENTRIES)) &
                    issued_r[wb_idx_s] & ~block_s;
  end

  // Entry as written at allocation.
  always_comb begin
    new_entry_s          = decoded_instr_i;
    new_entry_s.trans_id = 5'(alloc_ptr_r);
    new_entry_s.valid    = skips_issue(decoded_instr_i);
  end

  // Commit view of the oldest entry, optionally merged with this cycle's writeback.
  always_comb begin
    commit_entry_s = mem_r[commit_ptr_r];
`ifdef SCOREBOARD_COMMIT_BYPASS_EN
    if (wb_ok_s && (wb_idx_s == commit_ptr_r)) begin
      commit_entry_s.result = wdata_i;
      commit_entry_s.valid  = 1'b1;
      if (ex_i.valid) begin
        commit_entry_s.ex = ex_i;
      end else begin
        commit_entry_s.ex = mem_r[commit_ptr_r].ex;
      end
    end else begin
      commit_entry_s = mem_r[commit_ptr_r];
    end
`endif
    commit_valid_s = (count_r != CNT_W'(0)) & commit_entry_s.valid & ~block_s;
    commit_fire_s  = commit_valid_s & commit_ack_i;
  end

  // Output drive, forced to zero while blocked.
  always_comb begin
    full_o              = full_s & ~block_s;
    decoded_instr_ack_o = alloc_s;
    issue_instr_valid_o = issue_valid_s;
    commit_valid_o      = commit_valid_s;
    if (block_s) begin
      issue_instr_o  = '0;
      commit_instr_o = '0;
    end else begin
      issue_instr_o          = issue_entry_s;
      issue_instr_o.trans_id = 5'(issue_ptr_r);
      commit_instr_o         = commit_entry_s;
    end
  end

  // Buffer state; flush wins over every other update in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_r[i] <= '0;
      end
      issued_r     <= '0;
      alloc_ptr_r  <= '0;
      issue_ptr_r  <= '0;
      commit_ptr_r <= '0;
      count_r      <= '0;
      n_issued_r   <= '0;
      clear_r      <= 1'b1;
    end else if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_r[i].valid <= 1'b0;
      end
      issued_r     <= '0;
      alloc_ptr_r  <= '0;
      issue_ptr_r  <= '0;
      commit_ptr_r <= '0;
      count_r      <= '0;
      n_issued_r   <= '0;
      clear_r      <= 1'b1;
    end else begin
      clear_r <= 1'b0;
      if (alloc_s) begin
        mem_r[alloc_ptr_r]    <= new_entry_s;
        issued_r[alloc_ptr_r] <= skips_issue(decoded_instr_i);
        alloc_ptr_r           <= alloc_ptr_r + PTR_W'(1'b1);
      end
      if (issue_fire_s) begin
        issued_r[issue_ptr_r] <= 1'b1;
      end
      if (issue_adv_s) begin
        issue_ptr_r <= issue_ptr_r + PTR_W'(1'b1);
      end
      if (wb_ok_s) begin
        mem_r[wb_idx_s].result <= wdata_i;
        mem_r[wb_idx_s].valid  <= 1'b1;
        if (ex_i.valid) begin
          mem_r[wb_idx_s].ex <= ex_i;
        end
      end
      // Retire last so a bypassed writeback on the same slot is also cleared.
      if (commit_fire_s) begin
        mem_r[commit_ptr_r].valid <= 1'b0;
        issued_r[commit_ptr_r]    <= 1'b0;
        commit_ptr_r              <= commit_ptr_r + PTR_W'(1'b1);
      end
      count_r    <= count_r + CNT_W'(alloc_s) - CNT_W'(commit_fire_s);
      n_issued_r <= n_issued_r + CNT_W'(issue_adv_s) - CNT_W'(commit_fire_s);
    end
  end

  sb_hazard_check #(.NR_ENTRIES(NR_ENTRIES)) u_hazard (
    .entries   (mem_r),
    .commit_ptr(commit_ptr_r),
    .issue_ptr (issue_ptr_r),
    .rs1       (issue_entry_s.rs1),
    .rs2       (issue_entry_s.rs2),
    .use_imm   (issue_entry_s.use_imm),
    .use_pc    (issue_entry_s.use_pc),
    .hazard    (hazard_s)
  );

  scoreboard_checker #(.NR_ENTRIES(NR_ENTRIES)) u_checker (
    .clk_i   (clk_i),
    .active  (~block_s),
    .wb_valid(wb_valid_i),
    .trans_id(trans_id_i),
    .issued  (issued_r)
  );

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: reset, fill/wrap, RAW, out-of-order writeback,
// decode exceptions, flush and commit bypass timing.
module tb_scoreboard;
  import ariane_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush, dvalid, ack, full, issue_valid, issue_ack;
  logic              wb_valid, commit_valid, commit_ack;
  logic [4:0]        tid;
  logic [63:0]       wdata;
  exception_t        ex_in;
  scoreboard_entry_t dinstr, issue_instr, commit_instr;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  scoreboard dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .full_o               (full),
    .decoded_instr_i      (dinstr),
    .decoded_instr_valid_i(dvalid),
    .decoded_instr_ack_o  (ack),
    .issue_instr_o        (issue_instr),
    .issue_instr_valid_o  (issue_valid),
    .issue_ack_i          (issue_ack),
    .trans_id_i           (tid),
    .wdata_i              (wdata),
    .ex_i                 (ex_in),
    .wb_valid_i           (wb_valid),
    .commit_instr_o       (commit_instr),
    .commit_valid_o       (commit_valid),
    .commit_ack_i         (commit_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input logic [63:0] pc, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic exv);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = pc;
    e.fu       = ALU;
    e.rd       = rd;
    e.rs1      = rs1;
    e.rs2      = rs2;
    e.ex.valid = exv;
    e.ex.cause = exv ? ILLEGAL_INSTR : 64'd0;
    return e;
  endfunction

  // Advance to just after the next rising edge and return every input to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    flush      = 1'b0;
    dvalid     = 1'b0;
    dinstr     = '0;
    issue_ack  = 1'b0;
    wb_valid   = 1'b0;
    tid        = 5'd0;
    wdata      = 64'd0;
    ex_in      = '0;
    commit_ack = 1'b0;
  endtask

  task automatic wb(input logic [4:0] id, input logic [63:0] d);
    wb_valid = 1'b1;
    tid      = id;
    wdata    = d;
  endtask

  // One reset cycle; returns inside the quiet cycle that follows it.
  task automatic do_reset();
    cyc(); rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dvalid = 1'b0; dinstr = '0; issue_ack = 1'b0;
    wb_valid = 1'b0; tid = 5'd0; wdata = 64'd0; ex_in = '0; commit_ack = 1'b0;

    // 1: reset held two cycles with decode offering
    for (int r = 0; r < 2; r++) begin
      cyc(); rst = 1'b1; dvalid = 1'b1; dinstr = mk(64'h7, 5'd1, 5'd0, 5'd0, 1'b0); #1;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("rst_commit_valid", 64'(commit_valid), 64'd0);
      chk("rst_issue_zero", 64'(issue_instr != '0), 64'd0);
      chk("rst_commit_zero", 64'(commit_instr != '0), 64'd0);
    end
    cyc(); dvalid = 1'b1; dinstr = mk(64'h7, 5'd1, 5'd0, 5'd0, 1'b0); #1;
    chk("post_rst_ack", 64'(ack), 64'd0);
    chk("post_rst_issue_valid", 64'(issue_valid), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'h7, 5'd1, 5'd0, 5'd0, 1'b0); #1;
    chk("first_ack", 64'(ack), 64'd1);

    // 2: fill eight slots, ninth stalls until a commit has taken effect
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc(); dvalid = 1'b1; dinstr = mk(64'(k), 5'd0, 5'd0, 5'd0, 1'b0); #1;
      chk("fill_ack", 64'(ack), 64'(k < 8));
    end
    chk("fill_full", 64'(full), 64'd1);
    cyc(); dvalid = 1'b1; dinstr = mk(64'd8, 5'd0, 5'd0, 5'd0, 1'b0); issue_ack = 1'b1; #1;
    chk("fill_issue_valid", 64'(issue_valid), 64'd1);
    chk("fill_issue_id", 64'(issue_instr.trans_id), 64'd0);
    chk("fill_stall_ack", 64'(ack), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'd8, 5'd0, 5'd0, 5'd0, 1'b0); wb(5'd0, 64'hAA); #1;
    chk("fill_stall_ack2", 64'(ack), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'd8, 5'd0, 5'd0, 5'd0, 1'b0); commit_ack = 1'b1; #1;
    chk("fill_commit_valid", 64'(commit_valid), 64'd1);
    chk("fill_commit_result", commit_instr.result, 64'hAA);
    chk("fill_same_cycle_no_free", 64'(ack), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'd8, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("fill_ninth_ack", 64'(ack), 64'd1);
    chk("fill_not_full", 64'(full), 64'd0);
    for (int j = 0; j < 8; j++) begin
      cyc(); issue_ack = 1'b1; #1;
      chk("wrap_issue_valid", 64'(issue_valid), 64'd1);
      chk("wrap_issue_id", 64'(issue_instr.trans_id), 64'((j + 1) % 8));
      chk("wrap_issue_pc", issue_instr.pc, 64'(j + 1));
    end

    // 3: RAW on x5 blocks until the producer retires; x0 never blocks
    do_reset();
    cyc(); dvalid = 1'b1; dinstr = mk(64'h100, 5'd5, 5'd1, 5'd2, 1'b0); #1;
    chk("raw_add_ack", 64'(ack), 64'd1);
    chk("raw_empty_no_issue", 64'(issue_valid), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'h104, 5'd6, 5'd5, 5'd3, 1'b0); issue_ack = 1'b1; #1;
    chk("raw_add_issue", 64'(issue_valid), 64'd1);
    chk("raw_add_pc", issue_instr.pc, 64'h100);
    cyc(); #1;
    chk("raw_sub_blocked", 64'(issue_valid), 64'd0);
    cyc(); wb(5'd0, 64'h11); #1;
    chk("raw_sub_blocked_wb", 64'(issue_valid), 64'd0);
    cyc(); commit_ack = 1'b1; #1;
    chk("raw_sub_blocked_commit", 64'(issue_valid), 64'd0);
    chk("raw_add_commit_pc", commit_instr.pc, 64'h100);
    chk("raw_add_commit_result", commit_instr.result, 64'h11);
    cyc(); issue_ack = 1'b1; #1;
    chk("raw_sub_free", 64'(issue_valid), 64'd1);
    chk("raw_sub_id", 64'(issue_instr.trans_id), 64'd1);
    cyc(); dvalid = 1'b1; dinstr = mk(64'h108, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    cyc(); dvalid = 1'b1; dinstr = mk(64'h10C, 5'd7, 5'd0, 5'd0, 1'b0); issue_ack = 1'b1; #1;
    chk("x0_producer_issue", 64'(issue_valid), 64'd1);
    cyc(); issue_ack = 1'b1; #1;
    chk("x0_consumer_no_stall", 64'(issue_valid), 64'd1);
    chk("x0_consumer_pc", issue_instr.pc, 64'h10C);

    // 4: out-of-order writeback, in-order commit
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(); issue_ack = 1'b1;
      if (k < 3) begin
        dvalid = 1'b1; dinstr = mk(64'(10 + k), 5'd0, 5'd0, 5'd0, 1'b0);
      end
    end
    cyc(); wb(5'd2, 64'h22); #1;
    chk("ooo_no_commit", 64'(commit_valid), 64'd0);
    cyc(); wb(5'd0, 64'h20);
    cyc(); commit_ack = 1'b1; #1;
    chk("ooo_c0_valid", 64'(commit_valid), 64'd1);
    chk("ooo_c0_result", commit_instr.result, 64'h20);
    cyc(); #1;
    chk("ooo_c1_held", 64'(commit_valid), 64'd0);
    cyc(); wb(5'd1, 64'h21);
    cyc(); commit_ack = 1'b1; #1;
    chk("ooo_c1_valid", 64'(commit_valid), 64'd1);
    chk("ooo_c1_result", commit_instr.result, 64'h21);
    cyc(); commit_ack = 1'b1; #1;
    chk("ooo_c2_valid", 64'(commit_valid), 64'd1);
    chk("ooo_c2_pc", commit_instr.pc, 64'd12);
    chk("ooo_c2_result", commit_instr.result, 64'h22);
    cyc(); #1;
    chk("ooo_drained", 64'(commit_valid), 64'd0);

    // 5: decode exception skips issue and commits in order
    do_reset();
    cyc(); dvalid = 1'b1; dinstr = mk(64'h50, 5'd3, 5'd0, 5'd0, 1'b1); #1;
    cyc(); dvalid = 1'b1; dinstr = mk(64'h51, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("exc_not_issued", 64'(issue_valid), 64'd0);
    cyc(); issue_ack = 1'b1; commit_ack = 1'b1; #1;
    chk("exc_next_issue_valid", 64'(issue_valid), 64'd1);
    chk("exc_next_issue_pc", issue_instr.pc, 64'h51);
    chk("exc_next_issue_id", 64'(issue_instr.trans_id), 64'd1);
    chk("exc_commit_valid", 64'(commit_valid), 64'd1);
    chk("exc_commit_pc", commit_instr.pc, 64'h50);
    chk("exc_commit_cause", commit_instr.ex.cause, 64'd2);
    chk("exc_commit_exvalid", 64'(commit_instr.ex.valid), 64'd1);
    cyc(); wb(5'd1, 64'h55); #1;
    chk("exc_follow_wait", 64'(commit_valid), 64'd0);
    cyc(); commit_ack = 1'b1; #1;
    chk("exc_follow_commit", commit_instr.result, 64'h55);
    chk("exc_follow_exvalid", 64'(commit_instr.ex.valid), 64'd0);

    // 6: flush beats writeback/commit/alloc, then bypass timing on slot 0
    do_reset();
    cyc(); dvalid = 1'b1; dinstr = mk(64'h30, 5'd0, 5'd0, 5'd0, 1'b0); issue_ack = 1'b1;
    cyc(); dvalid = 1'b1; dinstr = mk(64'h31, 5'd0, 5'd0, 5'd0, 1'b0); issue_ack = 1'b1;
    cyc(); issue_ack = 1'b1;
    cyc(); wb(5'd0, 64'h40);
    cyc(); flush = 1'b1; wb(5'd1, 64'h41); commit_ack = 1'b1; dvalid = 1'b1;
    dinstr = mk(64'h60, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("flush_commit_valid", 64'(commit_valid), 64'd0);
    chk("flush_ack", 64'(ack), 64'd0);
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'h60, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("after_flush_ack", 64'(ack), 64'd0);
    chk("after_flush_commit_valid", 64'(commit_valid), 64'd0);
    chk("after_flush_full", 64'(full), 64'd0);
    cyc(); dvalid = 1'b1; dinstr = mk(64'h60, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("refill_ack", 64'(ack), 64'd1);
    chk("refill_empty_commit", 64'(commit_valid), 64'd0);
    cyc(); issue_ack = 1'b1; #1;
    chk("refill_issue_valid", 64'(issue_valid), 64'd1);
    chk("refill_issue_id", 64'(issue_instr.trans_id), 64'd0);
    chk("refill_issue_pc", issue_instr.pc, 64'h60);
    cyc(); wb(5'd0, 64'h77); #1;
`ifdef SCOREBOARD_COMMIT_BYPASS_EN
    chk("bypass_same_cycle", 64'(commit_valid), 64'd1);
    chk("bypass_result", commit_instr.result, 64'h77);
`else
    chk("bypass_same_cycle", 64'(commit_valid), 64'd0);
`endif
    cyc(); commit_ack = 1'b1; #1;
    chk("bypass_next_cycle", 64'(commit_valid), 64'd1);
    chk("bypass_next_result", commit_instr.result, 64'h77);
    cyc(); #1;
    chk("bypass_drained", 64'(commit_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
